// File: rtl/wf_player.sv
// Waveform playback stage: edge-triggered sample RAM writes, timed valid/ready playback.
// Optional external start trigger (adds i_wf_trig and an ARM state) via `define WF_EXT_TRIG_EN.
module wf_player #(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 32,
   parameter int DIV_WIDTH  = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [ADDR_WIDTH-1:0] i_s_addr,
   input  logic                  i_s_ce,
   input  logic [DATA_WIDTH-1:0] i_s_din,
   input  logic [1:0]            i_wf_en,
   input  logic [ADDR_WIDTH-1:0] i_wf_len,
   input  logic [DIV_WIDTH-1:0]  i_wf_div,
`ifdef WF_EXT_TRIG_EN
   input  logic                  i_wf_trig,
`endif
   output logic [DATA_WIDTH-1:0] o_wf_data,
   output logic                  o_wf_valid,
   input  logic                  i_wf_ready,
   output logic [ADDR_WIDTH-1:0] o_wf_cnt,
   output logic                  o_wf_busy,
   output logic                  o_wf_done,
   output logic                  o_wf_urun
);

   localparam int TW    = DIV_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH1 = 3'd1,
      ST_FETCH2 = 3'd2,
      ST_WAIT   = 3'd3,
      ST_PRES   = 3'd4,
`ifdef WF_EXT_TRIG_EN
      ST_ARM    = 3'd6,
`endif
      ST_DONE   = 3'd5
   } state_t;

   logic [DATA_WIDTH-1:0] ram [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] ram_rd_q;
   logic                  we_s;

   state_t                state_q, state_d;
   logic                  ce_q, ce_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, ocnt_q, ocnt_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   logic [TW-1:0]         t_q, t_d, per_s, pm1_s;
   logic [DATA_WIDTH-1:0] nxt_q, nxt_d, data_q, data_d;
   logic                  first_q, first_d, valid_q, valid_d, urun_q, urun_d;
   logic                  busy_q, busy_d, done_q, done_d, rise_s;

   // Rising-edge write strobe; read port is read-first because both use non-blocking updates.
   assign we_s = i_s_ce & ~ce_q & i_rst;

   always_ff @(posedge i_clk) begin
      if (we_s) begin
         ram[i_s_addr] <= i_s_din;
      end
      ram_rd_q <= ram[cnt_q];
   end

   always_comb begin
      ce_d    = i_s_ce;
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      div_d   = div_q;
      nxt_d   = nxt_q;
      data_d  = data_q;
      ocnt_d  = ocnt_q;
      first_d = first_q;
      valid_d = valid_q;
      urun_d  = urun_q;
      rise_s  = 1'b0;

      // Period minus one, clamped so the 4-cycle fetch pipeline always fits.
      per_s = {1'b0, div_q} + TW'(1);
      if (per_s < TW'(4)) begin
         pm1_s = TW'(3);
      end else begin
         pm1_s = per_s - TW'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (i_wf_en[0]) begin
               len_d   = i_wf_len;
               div_d   = i_wf_div;
               cnt_d   = {ADDR_WIDTH{1'b0}};
               urun_d  = 1'b0;
               first_d = 1'b1;
`ifdef WF_EXT_TRIG_EN
               state_d = ST_ARM;
`else
               state_d = ST_FETCH1;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
`ifdef WF_EXT_TRIG_EN
         ST_ARM: begin
            if (i_wf_trig) begin
               state_d = ST_FETCH1;
            end else begin
               state_d = ST_ARM;
            end
         end
`endif
         ST_FETCH1: state_d = ST_FETCH2;
         ST_FETCH2: begin
            nxt_d   = ram_rd_q;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // ">=" lets a sample delayed by an underrun go out without further waiting.
            if (first_q || (t_q >= pm1_s)) begin
               data_d  = nxt_q;
               valid_d = 1'b1;
               ocnt_d  = cnt_q;
               first_d = 1'b0;
               rise_s  = 1'b1;
               state_d = ST_PRES;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_PRES: begin
            if (i_wf_ready) begin
               valid_d = 1'b0;
               if (cnt_q != len_q) begin
                  cnt_d   = cnt_q + ADDR_WIDTH'(1);
                  state_d = ST_FETCH1;
               end else if (i_wf_en[1]) begin
                  cnt_d   = {ADDR_WIDTH{1'b0}};
                  state_d = ST_FETCH1;
               end else begin
                  state_d = ST_DONE;
               end
            end else if (t_q == pm1_s) begin
               urun_d = 1'b1;
            end else begin
               urun_d = urun_q;
            end
         end
         ST_DONE: begin
            if (!i_wf_en[0]) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Dropping run aborts playback; the last presented index stays visible.
      if (!i_wf_en[0] && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         cnt_d   = {ADDR_WIDTH{1'b0}};
      end else begin
         state_d = state_d;
      end

      if (rise_s) begin
         t_d = {TW{1'b0}};
      end else if (t_q == {TW{1'b1}}) begin
         t_d = t_q;
      end else begin
         t_d = t_q + TW'(1);
      end

      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= ST_IDLE;
         ce_q    <= 1'b0;
         cnt_q   <= {ADDR_WIDTH{1'b0}};
         len_q   <= {ADDR_WIDTH{1'b0}};
         div_q   <= {DIV_WIDTH{1'b0}};
         t_q     <= {TW{1'b0}};
         nxt_q   <= {DATA_WIDTH{1'b0}};
         data_q  <= {DATA_WIDTH{1'b0}};
         ocnt_q  <= {ADDR_WIDTH{1'b0}};
         first_q <= 1'b0;
         valid_q <= 1'b0;
         urun_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ce_q    <= ce_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         div_q   <= div_d;
         t_q     <= t_d;
         nxt_q   <= nxt_d;
         data_q  <= data_d;
         ocnt_q  <= ocnt_d;
         first_q <= first_d;
         valid_q <= valid_d;
         urun_q  <= urun_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign o_wf_data  = data_q;
   assign o_wf_valid = valid_q;
   assign o_wf_cnt   = ocnt_q;
   assign o_wf_busy  = busy_q;
   assign o_wf_done  = done_q;
   assign o_wf_urun  = urun_q;

endmodule

// File: tb/tb_wf_player.sv
// Directed, table-driven bench for wf_player; trigger checks built when WF_EXT_TRIG_EN is defined.
module tb_wf_player;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] s_addr;
   logic        s_ce;
   logic [31:0] s_din;
   logic [1:0]  en;
   logic [16:0] len;
   logic [31:0] div;
   logic [31:0] data;
   logic        valid;
   logic        ready;
   logic [16:0] cnt;
   logic        busy, done, urun;
`ifdef WF_EXT_TRIG_EN
   logic        trig;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   wf_player dut (
      .i_clk(clk), .i_rst(rst),
      .i_s_addr(s_addr), .i_s_ce(s_ce), .i_s_din(s_din),
      .i_wf_en(en), .i_wf_len(len), .i_wf_div(div),
`ifdef WF_EXT_TRIG_EN
      .i_wf_trig(trig),
`endif
      .o_wf_data(data), .o_wf_valid(valid), .i_wf_ready(ready),
      .o_wf_cnt(cnt), .o_wf_busy(busy), .o_wf_done(done), .o_wf_urun(urun)
   );

   typedef struct {
      string       name;
      int          adv;
      logic [1:0]  en;
      logic        rdy;
      logic [31:0] div;
      logic [16:0] len;
      logic        valid;
      logic [31:0] data;
      logic [16:0] cnt;
      logic        busy;
      logic        done;
      logic        urun;
   } vec_t;

   vec_t tab[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input string nm, input int adv, input logic [1:0] e, input logic r,
                      input logic [31:0] d, input logic [16:0] l, input logic v,
                      input logic [31:0] dt, input logic [16:0] c, input logic b,
                      input logic dn, input logic u);
      vec_t x;
      x.name = nm; x.adv = adv; x.en = e; x.rdy = r; x.div = d; x.len = l;
      x.valid = v; x.data = dt; x.cnt = c; x.busy = b; x.done = dn; x.urun = u;
      tab.push_back(x);
   endtask

   task automatic check(input string nm, input logic v, input logic [31:0] dt,
                        input logic [16:0] c, input logic b, input logic dn, input logic u);
      nvec++;
      if (valid !== v || data !== dt || cnt !== c || busy !== b || done !== dn || urun !== u) begin
         nerr++;
         $display("FAIL %s: got v=%0b d=%h c=%0d b=%0b dn=%0b u=%0b, want v=%0b d=%h c=%0d b=%0b dn=%0b u=%0b",
                  nm, valid, data, cnt, busy, done, urun, v, dt, c, b, dn, u);
      end
   endtask

   task automatic wr(input logic [16:0] a, input logic [31:0] d);
      s_addr = a; s_din = d; s_ce = 1'b1;
      tick();
      s_ce = 1'b0;
      tick();
   endtask

   task automatic play_idx2(input logic [31:0] exp);
      len = 17'd3; div = 32'd0; ready = 1'b1; en = 2'b01;
      repeat (12) tick();
      check("idx2_data", 1'b1, exp, 17'd2, 1'b1, 1'b0, 1'b0);
      en = 2'b00;
      tick();
      check("idx2_abort", 1'b0, exp, 17'd2, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b0; s_addr = '0; s_ce = 1'b0; s_din = '0; en = 2'b00;
      len = '0; div = '0; ready = 1'b0;
`ifdef WF_EXT_TRIG_EN
      trig = 1'b0;
`endif
      tick(); tick();
      check("reset", 1'b0, 32'h0, 17'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) wr(17'(i), 32'h100 + 32'(i));

      // one-shot, div=9 (P=10), len=3
      add("os_wait",   3, 2'b01, 1'b1, 32'd9, 17'd3, 1'b0, 32'h0,   17'd0, 1'b1, 1'b0, 1'b0);
      add("os_s0",     1, 2'b01, 1'b1, 32'd9, 17'd3, 1'b1, 32'h100, 17'd0, 1'b1, 1'b0, 1'b0);
      add("os_acc0",   1, 2'b01, 1'b1, 32'd9, 17'd3, 1'b0, 32'h100, 17'd0, 1'b1, 1'b0, 1'b0);
      add("os_gap",    8, 2'b01, 1'b1, 32'd9, 17'd3, 1'b0, 32'h100, 17'd0, 1'b1, 1'b0, 1'b0);
      add("os_s1",     1, 2'b01, 1'b1, 32'd9, 17'd3, 1'b1, 32'h101, 17'd1, 1'b1, 1'b0, 1'b0);
      add("os_s2",    10, 2'b01, 1'b1, 32'd9, 17'd3, 1'b1, 32'h102, 17'd2, 1'b1, 1'b0, 1'b0);
      add("os_s3",    10, 2'b01, 1'b1, 32'd9, 17'd3, 1'b1, 32'h103, 17'd3, 1'b1, 1'b0, 1'b0);
      add("os_done",   1, 2'b01, 1'b1, 32'd9, 17'd3, 1'b0, 32'h103, 17'd3, 1'b0, 1'b1, 1'b0);
      add("os_hold",  15, 2'b01, 1'b1, 32'd9, 17'd3, 1'b0, 32'h103, 17'd3, 1'b0, 1'b1, 1'b0);
      add("os_idle",   1, 2'b00, 1'b1, 32'd9, 17'd3, 1'b0, 32'h103, 17'd3, 1'b0, 1'b0, 1'b0);
      // looping
      add("lp_s0",     4, 2'b11, 1'b1, 32'd9, 17'd3, 1'b1, 32'h100, 17'd0, 1'b1, 1'b0, 1'b0);
      add("lp_s3",    30, 2'b11, 1'b1, 32'd9, 17'd3, 1'b1, 32'h103, 17'd3, 1'b1, 1'b0, 1'b0);
      add("lp_wrap",  10, 2'b11, 1'b1, 32'd9, 17'd3, 1'b1, 32'h100, 17'd0, 1'b1, 1'b0, 1'b0);
      add("lp_mid",    5, 2'b11, 1'b1, 32'd9, 17'd3, 1'b0, 32'h100, 17'd0, 1'b1, 1'b0, 1'b0);
      add("lp_s1",     5, 2'b11, 1'b0, 32'd9, 17'd3, 1'b1, 32'h101, 17'd1, 1'b1, 1'b0, 1'b0);
      add("lp_abort",  1, 2'b00, 1'b0, 32'd9, 17'd3, 1'b0, 32'h101, 17'd1, 1'b0, 1'b0, 1'b0);
      // div=0 clamps to a 4-cycle period
      add("cl_s0",     4, 2'b01, 1'b1, 32'd0, 17'd1, 1'b1, 32'h100, 17'd0, 1'b1, 1'b0, 1'b0);
      add("cl_s1",     4, 2'b01, 1'b1, 32'd0, 17'd1, 1'b1, 32'h101, 17'd1, 1'b1, 1'b0, 1'b0);
      add("cl_done",   1, 2'b01, 1'b1, 32'd0, 17'd1, 1'b0, 32'h101, 17'd1, 1'b0, 1'b1, 1'b0);
      add("cl_idle",   1, 2'b00, 1'b1, 32'd0, 17'd1, 1'b0, 32'h101, 17'd1, 1'b0, 1'b0, 1'b0);
      // underrun on sample 1
      add("ur_s0",     4, 2'b01, 1'b1, 32'd9, 17'd3, 1'b1, 32'h100, 17'd0, 1'b1, 1'b0, 1'b0);
      add("ur_acc0",   1, 2'b01, 1'b1, 32'd9, 17'd3, 1'b0, 32'h100, 17'd0, 1'b1, 1'b0, 1'b0);
      add("ur_s1",     9, 2'b01, 1'b0, 32'd9, 17'd3, 1'b1, 32'h101, 17'd1, 1'b1, 1'b0, 1'b0);
      add("ur_t8",     9, 2'b01, 1'b0, 32'd9, 17'd3, 1'b1, 32'h101, 17'd1, 1'b1, 1'b0, 1'b0);
      add("ur_set",    1, 2'b01, 1'b0, 32'd9, 17'd3, 1'b1, 32'h101, 17'd1, 1'b1, 1'b0, 1'b1);
      add("ur_held",  15, 2'b01, 1'b0, 32'd9, 17'd3, 1'b1, 32'h101, 17'd1, 1'b1, 1'b0, 1'b1);
      add("ur_acc1",   1, 2'b01, 1'b1, 32'd9, 17'd3, 1'b0, 32'h101, 17'd1, 1'b1, 1'b0, 1'b1);
      add("ur_s2",     3, 2'b01, 1'b1, 32'd9, 17'd3, 1'b1, 32'h102, 17'd2, 1'b1, 1'b0, 1'b1);
      add("ur_s3",    10, 2'b01, 1'b1, 32'd9, 17'd3, 1'b1, 32'h103, 17'd3, 1'b1, 1'b0, 1'b1);
      add("ur_done",   1, 2'b01, 1'b1, 32'd9, 17'd3, 1'b0, 32'h103, 17'd3, 1'b0, 1'b1, 1'b1);
      add("ur_sticky", 1, 2'b00, 1'b1, 32'd9, 17'd3, 1'b0, 32'h103, 17'd3, 1'b0, 1'b0, 1'b1);
      add("ur_clear",  1, 2'b01, 1'b1, 32'd9, 17'd3, 1'b0, 32'h103, 17'd3, 1'b1, 1'b0, 1'b0);
      add("ur_idle",   1, 2'b00, 1'b1, 32'd9, 17'd3, 1'b0, 32'h103, 17'd3, 1'b0, 1'b0, 1'b0);

      foreach (tab[i]) begin
         en = tab[i].en; ready = tab[i].rdy; div = tab[i].div; len = tab[i].len;
         repeat (tab[i].adv) tick();
         check(tab[i].name, tab[i].valid, tab[i].data, tab[i].cnt, tab[i].busy,
               tab[i].done, tab[i].urun);
      end

      // ce held high with changing data must write only once, on its rising edge
      s_addr = 17'd2; s_din = 32'hAAAA; s_ce = 1'b1;
      tick();
      s_din = 32'hDDDD;
      repeat (4) tick();
      s_ce = 1'b0;
      tick();
      play_idx2(32'hAAAA);
      wr(17'd2, 32'hBBBB);
      play_idx2(32'hBBBB);

      // reset mid-run
      ready = 1'b0; len = 17'd3; div = 32'd9; en = 2'b01;
      repeat (4) tick();
      check("rst_pre", 1'b1, 32'h100, 17'd0, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      check("rst_mid", 1'b0, 32'h0, 17'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1; en = 2'b00;
      tick();
      check("rst_idle", 1'b0, 32'h0, 17'd0, 1'b0, 1'b0, 1'b0);

`ifdef WF_EXT_TRIG_EN
      ready = 1'b1; en = 2'b01;
      repeat (50) tick();
      check("arm_wait", 1'b0, 32'h0, 17'd0, 1'b1, 1'b0, 1'b0);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      repeat (2) tick();
      check("trig_n3", 1'b0, 32'h0, 17'd0, 1'b1, 1'b0, 1'b0);
      tick();
      check("trig_n4", 1'b1, 32'h100, 17'd0, 1'b1, 1'b0, 1'b0);
      en = 2'b00;
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/wf_player.md
Name: wf_player

Overview:
- Waveform playback stage directly downstream of the AXI4-Lite waveform register block.
- Consumes that block's sample-memory write port (addr/ce/din) and enable bits, and stores samples in an internal single-clock RAM.
- On run, plays samples out at a programmable period over a valid/ready stream to the DAC/controller path.
- Returns the live sample index (o_wf_cnt) for readback through the register block.

Parameters:
ADDR_WIDTH, 17, sample-memory address width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 32, sample width
DIV_WIDTH, 32, period-divider width

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-low reset
i_s_addr  in  ADDR_WIDTH  sample-memory write address
i_s_ce  in  1  write strobe, level from register; write on its rising edge only
i_s_din  in  DATA_WIDTH  sample-memory write data
i_wf_en  in  2  bit0 run, bit1 loop
i_wf_len  in  ADDR_WIDTH  index of last sample (sample count minus 1)
i_wf_div  in  DIV_WIDTH  sample period in clocks minus 1
o_wf_data  out  DATA_WIDTH  presented sample
o_wf_valid  out  1  sample valid
i_wf_ready  in  1  downstream accept
o_wf_cnt  out  ADDR_WIDTH  index of sample currently or last presented
o_wf_busy  out  1  high in any state except IDLE and DONE
o_wf_done  out  1  high in DONE
o_wf_urun  out  1  sticky underrun flag

Behaviour:
- Reset (i_rst=0 at a clock edge): all outputs 0, FSM=IDLE, timer=0, ce edge register=0. RAM contents are not cleared. Reset mid-run aborts immediately.
- Write port:
  - ce_d <= i_s_ce.
  - Write RAM[i_s_addr] <= i_s_din when i_s_ce & ~ce_d.
  - Writes are accepted in every state.
  - A same-cycle read of the written address returns old data (read-first).
- Period: P = max(div_l+1, 4), where div_l is i_wf_div latched at start. Computed in DIV_WIDTH+1 bits, so no overflow.
- Timer t: cleared to 0 in the cycle o_wf_valid rises; otherwise increments each cycle and saturates at all-ones.
- FSM states IDLE, FETCH1, FETCH2, WAIT, PRES, DONE:
  - IDLE:
    - if i_wf_en[0]=1: latch len_l=i_wf_len and div_l, set cnt=0, clear o_wf_urun, set first=1, go FETCH1.
  - FETCH1: RAM read address = cnt; go FETCH2.
  - FETCH2: RAM output registered into data_nxt; go WAIT.
  - WAIT:
    - if first=1 or t==P-1: o_wf_data<=data_nxt, o_wf_valid<=1, o_wf_cnt<=cnt, t<=0, first<=0, go PRES.
  - PRES (o_wf_valid=1, o_wf_data stable):
    - If t==P-1 and i_wf_ready=0: set o_wf_urun.
    - On i_wf_ready=1: o_wf_valid<=0, then:
      - if cnt==len_l and loop=0: go DONE;
      - if cnt==len_l and loop=1: cnt<=0, go FETCH1;
      - otherwise cnt<=cnt+1, go FETCH1.
    - After an underrun, the next sample is presented at the WAIT state's first cycle, since t already exceeds P-1. WAIT therefore uses t>=P-1.
  - DONE: outputs hold, o_wf_done=1; stays until i_wf_en[0]=0, then goes IDLE.
- i_wf_en[0]=0 in any state other than IDLE or DONE: next cycle IDLE, o_wf_valid=0, cnt=0. o_wf_cnt holds its last value.
- Loop bit is sampled live at each wrap decision. len and div changes take effect only at the next start.
- Latency: i_wf_en[0] sampled high in IDLE at cycle 0 gives o_wf_valid=1 at cycle 4.
- Steady state with i_wf_ready=1: valid rising edges exactly P cycles apart.
- len=0: the single sample replays every P cycles when looping; otherwise one sample, then DONE.

Optional Feature:
- Macro WF_EXT_TRIG_EN.
- Defined:
  - Adds port i_wf_trig (in, 1) and state ARM.
  - IDLE with run=1 latches parameters as normal but goes to ARM instead of FETCH1.
  - ARM goes to FETCH1 on the cycle i_wf_trig=1.
  - ARM counts as busy.
  - Run=0 in ARM returns to IDLE.
- Undefined: no port, no ARM state; start is immediate.

Test Plan:
- Write 0x100..0x103 to addr 0..3 via ce pulses; len=3, div=9, en=01, ready=1 -> valid at cycle 4; data 0x100, 0x101, 0x102, 0x103 at 10-cycle spacing, o_wf_cnt 0..3; then done=1, no fifth valid; en=00 -> IDLE, done=0.
- Same load, en=11 -> repeating 0x100..0x103, o_wf_cnt wraps 3->0, spacing 10, busy=1 throughout; en=00 mid-sample -> valid=0 next cycle.
- div=0, len=1 -> valid edges 4 cycles apart (clamped), urun=0.
- div=9, ready held low 25 cycles on sample 1 -> data stays 0x101 and valid stays high; urun=1 at t=9; after accept, 0x102 valid 3 cycles later; urun sticky until next start.
- i_s_ce held high 5 cycles with addr 2, din 0xAAAA -> exactly one write; a second ce pulse with 0xBBBB then playback shows 0xBBBB at index 2; i_rst=0 mid-run -> all outputs 0 next cycle.
- WF_EXT_TRIG_EN: en=01, no trig for 50 cycles -> no valid, busy=1; trig pulse at cycle N -> valid at N+4.
